// File: rtl/fifo_stream_pkg.sv
// Shared types for the FIFO read-side stream adapter.
package fifo_stream_pkg;
    typedef enum logic [1:0] {ST_EMPTY, ST_ONE, ST_TWO} fifo_stream_state_e;
    localparam int OCC_MAX = 2;
endpackage

// File: rtl/fifo_stream_out.sv
// Read-side adapter: pops a synchronous FIFO into a 2-entry registered skid buffer
// and presents the words as a valid/ready stream with no out_ready -> fifo_ren path.
module fifo_stream_out
    import fifo_stream_pkg::*;
#(
    parameter type T = logic
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       fifo_empty,
    output logic       fifo_ren,
    input  T           fifo_data,
    output logic       out_valid,
    input  logic       out_ready,
    output T           out_data,
    output logic [1:0] occupancy
);

    fifo_stream_state_e state_q, state_d;
    T                   main_q, main_d;
    T                   skid_q, skid_d;

    // Pop decision uses only registered state, so back-pressure never reaches the FIFO combinationally.
    assign fifo_ren  = !fifo_empty && (state_q != ST_TWO) && !flush && !rst;
    assign out_valid = (state_q != ST_EMPTY);
    assign out_data  = main_q;

    always_comb begin
        occupancy = 2'd0;
        case (state_q)
            ST_ONE:  occupancy = 2'd1;
            ST_TWO:  occupancy = 2'd2;
            default: occupancy = 2'd0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (fifo_ren) begin
                        state_d = ST_ONE;
                        main_d  = fifo_data;
                    end
                end
                ST_ONE: begin
                    if (fifo_ren && out_ready) begin
                        main_d = fifo_data;
                    end else if (fifo_ren) begin
                        state_d = ST_TWO;
                        skid_d  = fifo_data;
                    end else if (out_ready) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    // Skid word is always older than anything still in the FIFO.
                    if (out_ready) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    a_no_pop_empty: assert property (@(posedge clk) disable iff (rst) !(fifo_ren && fifo_empty));
    a_no_pop_two:   assert property (@(posedge clk) disable iff (rst) !(fifo_ren && state_q == ST_TWO));
    a_stable:       assert property (@(posedge clk) disable iff (rst)
                        (out_valid && !out_ready && !flush) |=> (out_valid && $stable(out_data)));
    a_occ_max:      assert property (@(posedge clk) disable iff (rst) occupancy <= 2'(OCC_MAX));

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed and randomized bench for fifo_stream_out against a queue-based reference model.
module tb_fifo_stream_out;

    typedef logic [7:0] word_t;

    logic       clk;
    logic       rst;
    logic       flush;
    logic       fifo_empty;
    logic       fifo_ren;
    word_t      fifo_data;
    logic       out_valid;
    logic       out_ready;
    word_t      out_data;
    logic [1:0] occupancy;

    fifo_stream_out #(.T(word_t)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .fifo_empty(fifo_empty),
        .fifo_ren  (fifo_ren),
        .fifo_data (fifo_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .occupancy (occupancy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream FIFO contents and words held by the adapter, oldest first.
    word_t fq[$];
    word_t mb[$];
    bit    known;
    bit    zero_known;
    int    n_assert;
    int    n_fail;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle(input bit rst_v, input bit flush_v, input bit rdy_v);
        bit pop_e;
        bit xfer_e;
        rst        = rst_v;
        flush      = flush_v;
        out_ready  = rdy_v;
        fifo_empty = (fq.size() == 0);
        fifo_data  = fifo_empty ? word_t'($urandom) : fq[0];
        pop_e      = !fifo_empty && (mb.size() < 2) && !flush_v && !rst_v;
        @(negedge clk);
        check("fifo_ren", fifo_ren, pop_e);
        if (known) begin
            check("out_valid", out_valid, mb.size() > 0);
            check("occupancy", occupancy, mb.size());
            if (mb.size() > 0)
                check("out_data", out_data, mb[0]);
            else if (zero_known)
                check("out_data_reset", out_data, 0);
        end
        xfer_e = (mb.size() > 0) && rdy_v;
        @(posedge clk);
        if (rst_v) begin
            mb.delete();
            known      = 1'b1;
            zero_known = 1'b1;
        end else if (flush_v) begin
            mb.delete();
            zero_known = 1'b0;
        end else begin
            if (xfer_e) void'(mb.pop_front());
            if (pop_e) begin
                mb.push_back(fq.pop_front());
                zero_known = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        n_assert   = 0;
        n_fail     = 0;
        known      = 1'b0;
        zero_known = 1'b0;
        rst        = 1'b1;
        flush      = 1'b0;
        out_ready  = 1'b0;
        fifo_empty = 1'b1;
        fifo_data  = '0;

        // Reset with a non-empty FIFO, then stream 0x01..0x10.
        for (int i = 1; i <= 16; i++) fq.push_back(word_t'(i));
        cycle(1, 0, 1);
        cycle(1, 0, 1);
        for (int i = 0; i < 19; i++) cycle(0, 0, 1);

        // Back-pressure fills both entries, then drains in order.
        fq.push_back(8'hA1);
        fq.push_back(8'hA2);
        fq.push_back(8'hA3);
        for (int i = 0; i < 4; i++) cycle(0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 1);

        // Single word drains to empty.
        fq.push_back(8'h5A);
        for (int i = 0; i < 4; i++) cycle(0, 0, 1);

        // Flush in TWO; 0x33 follows.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(0, 1, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);

        // Same with a mid-stream reset.
        fq.push_back(8'h11);
        fq.push_back(8'h22);
        fq.push_back(8'h33);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0);
        cycle(1, 0, 0);
        for (int i = 0; i < 3; i++) cycle(0, 0, 1);

        // Randomized traffic, back-pressure, flushes and resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) != 0 && fq.size() < 8) fq.push_back(word_t'($urandom));
            cycle($urandom_range(0, 49) == 0, $urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
        end
        for (int i = 0; i < 12; i++) cycle(0, 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
